// File: rtl/frame_buf_sched.sv
// Triple-buffer bank scheduler for the camera-write / HDMI-read ports of the DDR3 frame store.
// Keeps writer, reader and spare banks disjoint and always hands the reader the newest finished frame.
module frame_buf_sched #(
    parameter int ADDR_W       = 29,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_STRIDE = 384000,
    parameter int FRAME_SIZE   = 384000,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    input  logic              rd_frame_start,
    output logic [ADDR_W-1:0] wr_addr_min,
    output logic [ADDR_W-1:0] wr_addr_max,
    output logic [ADDR_W-1:0] rd_addr_min,
    output logic [ADDR_W-1:0] rd_addr_max,
    output logic [1:0]        wr_bank,
    output logic [1:0]        rd_bank,
    output logic              rd_frame_valid,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt,
    output logic [CNT_W-1:0]  abort_cnt
);

    localparam logic [ADDR_W-1:0] BANK0_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(BASE_ADDR + FRAME_STRIDE);
    localparam logic [ADDR_W-1:0] BANK2_BASE = ADDR_W'(BASE_ADDR + 2 * FRAME_STRIDE);
    localparam logic [ADDR_W-1:0] SIZE       = ADDR_W'(FRAME_SIZE);

    logic [1:0]       wr_idx, rd_idx, spare_idx;
    logic             ready, wr_active;

    logic [1:0]       wr_idx_n, rd_idx_n, spare_idx_n;
    logic             ready_n, wr_active_n, rd_frame_valid_n;
    logic [CNT_W-1:0] drop_cnt_n, repeat_cnt_n, abort_cnt_n;
    logic [1:0]       swap_tmp;

    function automatic logic [ADDR_W-1:0] bank_base(input logic [1:0] idx);
        case (idx)
            2'd0:    return BANK0_BASE;
            2'd1:    return BANK1_BASE;
            default: return BANK2_BASE;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

    // Events are folded in the fixed order done -> write start -> read start,
    // each stage seeing the result of the previous one.
    always_comb begin
        wr_idx_n         = wr_idx;
        rd_idx_n         = rd_idx;
        spare_idx_n      = spare_idx;
        ready_n          = ready;
        wr_active_n      = wr_active;
        rd_frame_valid_n = rd_frame_valid;
        drop_cnt_n       = drop_cnt;
        repeat_cnt_n     = repeat_cnt;
        abort_cnt_n      = abort_cnt;
        swap_tmp         = 2'd0;

        if (wr_frame_done && wr_active_n) begin
            if (ready_n) begin
                drop_cnt_n = sat_inc(drop_cnt_n);
            end
            swap_tmp    = wr_idx_n;
            wr_idx_n    = spare_idx_n;
            spare_idx_n = swap_tmp;
            ready_n     = 1'b1;
            wr_active_n = 1'b0;
        end

        if (wr_frame_start) begin
            if (wr_active_n) begin
                abort_cnt_n = sat_inc(abort_cnt_n);
            end
            wr_active_n = 1'b1;
        end

        if (rd_frame_start) begin
            if (ready_n) begin
                swap_tmp         = rd_idx_n;
                rd_idx_n         = spare_idx_n;
                spare_idx_n      = swap_tmp;
                ready_n          = 1'b0;
                rd_frame_valid_n = 1'b1;
            end else if (rd_frame_valid_n) begin
                repeat_cnt_n = sat_inc(repeat_cnt_n);
            end
        end
    end

    // Address outputs are registered from the next-state indices so they move in
    // the same cycle as the bank indices.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx         <= 2'd0;
            rd_idx         <= 2'd1;
            spare_idx      <= 2'd2;
            ready          <= 1'b0;
            wr_active      <= 1'b0;
            rd_frame_valid <= 1'b0;
            drop_cnt       <= '0;
            repeat_cnt     <= '0;
            abort_cnt      <= '0;
            wr_addr_min    <= BANK0_BASE;
            wr_addr_max    <= BANK0_BASE + SIZE;
            rd_addr_min    <= BANK1_BASE;
            rd_addr_max    <= BANK1_BASE + SIZE;
        end else begin
            wr_idx         <= wr_idx_n;
            rd_idx         <= rd_idx_n;
            spare_idx      <= spare_idx_n;
            ready          <= ready_n;
            wr_active      <= wr_active_n;
            rd_frame_valid <= rd_frame_valid_n;
            drop_cnt       <= drop_cnt_n;
            repeat_cnt     <= repeat_cnt_n;
            abort_cnt      <= abort_cnt_n;
            wr_addr_min    <= bank_base(wr_idx_n);
            wr_addr_max    <= bank_base(wr_idx_n) + SIZE;
            rd_addr_min    <= bank_base(rd_idx_n);
            rd_addr_max    <= bank_base(rd_idx_n) + SIZE;
        end
    end

    assign wr_bank = wr_idx;
    assign rd_bank = rd_idx;

    bank_permutation: assert property (@(posedge clk) disable iff (reset)
        (wr_idx < 2'd3) && (rd_idx < 2'd3) && (spare_idx < 2'd3) &&
        (wr_idx != rd_idx) && (wr_idx != spare_idx) && (rd_idx != spare_idx));

endmodule

// File: doc/frame_buf_sched.md
Name: frame_buf_sched

Overview:
- Triple-buffer scheduler for the shared DDR3 frame store between the camera write port and the HDMI read port of the 2-port DDR3 controller.
- Assigns one of three frame banks to the writer and one to the reader, so the reader never scans a bank that is being written.
- Always hands the reader the newest completed frame.
- Drives the per-port base addresses (min/max) into the DDR3 controller and reports dropped, repeated and aborted frames.
- Event inputs are single-cycle pulses already synchronised to clk; the CDC synchronisers sit upstream.

Parameters:
- ADDR_W, 29, width of DDR3 app address.
- BASE_ADDR, 0, address of bank 0.
- FRAME_STRIDE, 384000, address distance between banks (800*480 words).
- FRAME_SIZE, 384000, words per frame; sets the max address.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  scheduler clock.
- reset  in  1  synchronous, active-high reset.
- wr_frame_start  in  1  pulse: writer begins a frame (from wr_load).
- wr_frame_done  in  1  pulse: writer completed the last burst of a frame.
- rd_frame_start  in  1  pulse: reader begins a frame (from rd_load).
- wr_addr_min  out  ADDR_W  base of the current write bank.
- wr_addr_max  out  ADDR_W  wr_addr_min + FRAME_SIZE.
- rd_addr_min  out  ADDR_W  base of the current read bank.
- rd_addr_max  out  ADDR_W  rd_addr_min + FRAME_SIZE.
- wr_bank  out  2  current write bank index.
- rd_bank  out  2  current read bank index.
- rd_frame_valid  out  1  read bank holds a completed frame; display blanks while 0.
- drop_cnt  out  CNT_W  completed frames overwritten before being read.
- repeat_cnt  out  CNT_W  read starts with no new frame.
- abort_cnt  out  CNT_W  write frames restarted before done.

Behaviour:
- State:
  - Bank indices wr_idx, rd_idx, spare_idx; always a permutation of {0,1,2}.
  - ready flag: spare bank holds the newest unread completed frame.
  - wr_active flag.
- Reset values: wr_idx=0, rd_idx=1, spare_idx=2, ready=0, wr_active=0, rd_frame_valid=0, all counters 0.
  - Address outputs reflect these indices: wr_addr_min=BASE_ADDR, rd_addr_min=BASE_ADDR+FRAME_STRIDE.
- Address arithmetic: addr_min = BASE_ADDR + idx*FRAME_STRIDE, addr_max = addr_min + FRAME_SIZE.
  - Computed in ADDR_W bits, truncating.
  - Parameters are chosen so that BASE_ADDR + 3*FRAME_STRIDE < 2^ADDR_W.
- All outputs are registered and update on the clock edge after the triggering pulse (1-cycle latency).
- Outputs never change without an event.
- wr_frame_start:
  - If wr_active=1: abort_cnt++, bank unchanged (the partial frame is overwritten).
  - Sets wr_active=1.
- wr_frame_done:
  - Ignored if wr_active=0.
  - Otherwise: swap wr_idx<->spare_idx, set ready=1, clear wr_active.
  - If ready was already 1: drop_cnt++.
- rd_frame_start:
  - If ready=1: swap rd_idx<->spare_idx, clear ready, set rd_frame_valid=1.
  - If ready=0: indices unchanged, repeat_cnt++ (only when rd_frame_valid=1), so the previous frame is re-read.
- Simultaneous events in one cycle are applied in order: done, then start (write), then read start.
  - done+rd_start: new wr=old spare, rd=old wr, spare=old rd, ready=0. drop_cnt++ if ready was 1 beforehand.
  - done+wr_start same cycle: the frame completes, then a new frame starts on the new bank with no abort.
- Counters saturate at 2^CNT_W-1.
- Reset mid-operation returns every register to its reset values the next edge, regardless of pending pulses.
- Invariant checked by assertion: wr_idx, rd_idx, spare_idx pairwise distinct and each <3.

Test Plan:
- Reset, no events -> wr_bank=0, rd_bank=1, rd_frame_valid=0, wr_addr_min=0, rd_addr_min=384000, rd_addr_max=768000.
- wr_start, wr_done, rd_start (separate cycles) -> after rd_start: rd_bank=0, wr_bank=2, rd_frame_valid=1, rd_addr_min=0; counters 0.
- From reset, three write frames (start/done each) with no read -> drop_cnt=2, ready=1.
  - Next rd_start gives rd_bank = last written bank, and that bank ≠ wr_bank.
- After one frame has been read, two rd_start with no new write -> repeat_cnt=2, rd_bank unchanged.
- wr_start, wr_start, wr_done -> abort_cnt=1, one ready frame, wr_bank swapped once.
- wr_done and rd_start in the same cycle with ready=0, wr_idx=0, rd_idx=1, spare=2 -> rd_bank=0, wr_bank=2, spare=1, drop_cnt=0.
  - Assert reset mid-frame -> next cycle all reset values.
